wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port (integer and FP regfiles, one rd address/data bus) between the in-order pipeline WB slot and NUM_LU long-latency units (FP div/sqrt, mul).
- Pipeline WB has fixed top priority.
- Long-latency results are held in one-entry buffers and granted round-robin.
- A starvation counter requests a pipeline bubble so held results always drain.
- Sits between WB/long-latency units and the ID stage regfile write inputs (reg_write, reg_FP_write, rd addr/data).

Parameters:
NUM_LU, 2, number of long-latency requesters (1..4)
STARVE_MAX, 8, consecutive cycles a held LU result may wait before a bubble is requested (2..255)
DATA_W, `DATA_WIDTH (32), write data width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
pipe_wb_valid  input  1  pipeline WB slot carries a register write
pipe_wb_fp  input  1  1 = FP regfile target, 0 = integer
pipe_wb_addr  input  5  destination register
pipe_wb_data  input  DATA_W  write data
lu_valid  input  NUM_LU  per-unit result valid
lu_ready  output  NUM_LU  per-unit buffer free
lu_fp  input  NUM_LU  per-unit FP target flag
lu_addr  input  5*NUM_LU  packed destination registers, unit i at [5i+4:5i]
lu_data  input  DATA_W*NUM_LU  packed data, unit i at [DATA_W*i +: DATA_W]
reg_write  output  1  integer regfile write enable
reg_FP_write  output  1  FP regfile write enable
reg_rd_addr  output  5  write address
reg_rd_data  output  DATA_W  write data
grant_id  output  3  source of current write: 0 = pipeline, i+1 = unit i, 7 = none
pipe_stall  output  1  request: WB slot must be empty next cycle
proto_err  output  1  sticky: pipe_wb_valid seen in a cycle following pipe_stall

Behaviour:
- Reset (rst==0 at posedge) clears:
  - all buffers, counter, FSM state to ARB, rr pointer to 0, proto_err
  - reg_write=0, reg_FP_write=0, reg_rd_addr=0, reg_rd_data=0, grant_id=7, pipe_stall=0
- Reset mid-operation discards held results. LUs must be reset together with this block.
- LU handshake:
  - Transfer on lu_valid[i] & lu_ready[i].
  - lu_ready[i] = ~buf_v[i], combinational from state only. A same-cycle grant does not free the buffer for a same-cycle transfer.
  - Buffer i clears at the posedge where it is granted.
- Grant, evaluated each cycle:
  - If pipe_wb_valid: pipeline wins.
  - Else: first set buf_v[j] searching from rr_ptr upward with wrap-around. rr_ptr <= j+1 mod NUM_LU.
  - Else: no grant.
- Output registers:
  - All write-port outputs are registered, so a write appears one cycle after grant.
  - The regfile (clocked on ~clk) commits it mid-cycle.
- Enable rules:
  - Integer grant: reg_write=1 only if addr != 0. The x0 grant is consumed with no write.
  - FP grant: reg_FP_write=1 for any addr, including f0.
  - Never both enables in one cycle.
  - grant_id reflects the registered grant. It shows the source even for a suppressed x0 write.
- Starvation FSM (ARB, BUBBLE):
  - In ARB, the counter increments each cycle any buf_v is set and no LU is granted.
  - The counter clears on any LU grant or when all buffers are empty.
  - When counter == STARVE_MAX-1 and increments: go to BUBBLE and register pipe_stall=1 for exactly one cycle.
  - In BUBBLE: pipe_wb_valid must be 0, so an LU is granted. Clear counter and return to ARB.
  - If pipe_wb_valid=1 in BUBBLE: pipeline still wins, proto_err is set (sticky), and the FSM re-enters BUBBLE next cycle.
- Ordering / WAW: grants follow the rules above only. Keeping a younger pipeline write from being overwritten by an older LU result is issue-logic scoreboard responsibility.
- Simultaneous LU transfer and pipeline write: both accepted. The LU result waits in its buffer.

Optional Feature:
WB_ARB_HAZARD_EN:
- Defined: adds inputs id_rs1_addr and id_rs2_addr (5 each) and outputs hazard_rs1 and hazard_rs2.
- hazard_rsN is combinational: high when any valid buffer or the registered in-flight write targets the same address and regfile type as the ID read. The type is selected by an added input id_fp_read.
- Integer x0 never hazards.
- Undefined: ports absent, no comparator logic.

Decomposition:
- Package wb_arb_pkg:
  - grant_id encodings GNT_PIPE=0 and GNT_NONE=7
  - FSM enum {ARB, BUBBLE}
  - typedef wb_req_t {fp, addr[4:0], data}
- Sub-module rr_picker (NUM_LU-wide rotate-priority find-first with pointer input, combinational) is natural. The top holds buffers, FSM and output registers.

Test Plan:
- Reset then idle: all outputs 0, grant_id=7, lu_ready=all 1 for 5 cycles.
- pipe_wb_valid=1, int, addr 5, data 0xDEAD_BEEF, while lu_valid[0]=1 with addr 6 -> cycle+1: reg_write=1, addr 5, grant_id=0. Pipe idle next -> cycle+2: addr 6, grant_id=1, lu_ready[0] returns 1 the following cycle.
- Int write to addr 0 from pipe -> reg_write=0, grant_id=0. FP write to f0 -> reg_FP_write=1, addr 0.
- Both LUs buffered, pipe idle 4 cycles -> grants alternate unit0, unit1. The pointer wraps, and a new unit0 result is granted before unit1's second result.
- STARVE_MAX=8, LU0 buffered, pipe_wb_valid=1 continuously -> pipe_stall=1 for exactly one cycle, 8 cycles after buffering. Driving pipe_wb_valid=0 next cycle -> LU0 granted, counter cleared.
- pipe_wb_valid held 1 through BUBBLE -> proto_err=1 and stays 1 until reset. Assert reset mid-buffer -> buffers empty, lu_ready all 1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and encodings for the register-file write-port arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_arb_pkg;

    localparam int unsigned WB_DATA_W = `DATA_WIDTH;

    localparam logic [2:0] GNT_PIPE = 3'd0;
    localparam logic [2:0] GNT_NONE = 3'd7;

    typedef enum logic {
        ARB,
        BUBBLE
    } arb_state_e;

    typedef struct packed {
        logic                 fp;
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority find-first: first set request at or above ptr, wrapping around.
module rr_picker #(
    parameter int unsigned NUM_LU = 2
) (
    input  logic [NUM_LU-1:0] req,
    input  logic [1:0]        ptr,
    output logic              pick_v,
    output logic [1:0]        pick_idx
);

    logic [1:0] cand;

    always_comb begin
        pick_v   = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_LU; k++) begin
            cand = 2'((32'(ptr) + k) % NUM_LU);
            if (!pick_v && req[cand]) begin
                pick_v   = 1'b1;
                pick_idx = cand;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB first, then round-robin over held LU results.
// Optional WB_ARB_HAZARD_EN adds ID-stage read hazard outputs against buffered/in-flight writes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_LU     = 2,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned DATA_W     = `DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef WB_ARB_HAZARD_EN
    input  logic [4:0]               id_rs1_addr,
    input  logic [4:0]               id_rs2_addr,
    input  logic                     id_fp_read,
    output logic                     hazard_rs1,
    output logic                     hazard_rs2,
`endif
    input  logic                     pipe_wb_valid,
    input  logic                     pipe_wb_fp,
    input  logic [4:0]               pipe_wb_addr,
    input  logic [DATA_W-1:0]        pipe_wb_data,
    input  logic [NUM_LU-1:0]        lu_valid,
    output logic [NUM_LU-1:0]        lu_ready,
    input  logic [NUM_LU-1:0]        lu_fp,
    input  logic [5*NUM_LU-1:0]      lu_addr,
    input  logic [DATA_W*NUM_LU-1:0] lu_data,
    output logic                     reg_write,
    output logic                     reg_FP_write,
    output logic [4:0]               reg_rd_addr,
    output logic [DATA_W-1:0]        reg_rd_data,
    output logic [2:0]               grant_id,
    output logic                     pipe_stall,
    output logic                     proto_err
);

    wb_req_t     lu_buf [NUM_LU];
    logic [NUM_LU-1:0] lu_buf_v;
    logic [1:0]  rr_ptr;
    logic [7:0]  starve_cnt, starve_cnt_n;
    arb_state_e  state_q, state_n;
    logic        proto_set;

    logic        pick_v;
    logic [1:0]  pick_idx;
    logic        lu_gnt_v;
    wb_req_t     gnt_req;

    assign lu_ready = ~lu_buf_v;

    rr_picker #(
        .NUM_LU(NUM_LU)
    ) u_picker (
        .req      (lu_buf_v),
        .ptr      (rr_ptr),
        .pick_v   (pick_v),
        .pick_idx (pick_idx)
    );

    assign lu_gnt_v = !pipe_wb_valid && pick_v;

    always_comb begin
        gnt_req = lu_buf[pick_idx];
    end

    // Buffer i is freed only by its grant; its ready stays low that cycle, so load never collides.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lu_buf_v <= '0;
            rr_ptr   <= '0;
            for (int unsigned i = 0; i < NUM_LU; i++) begin
                lu_buf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LU; i++) begin
                if (lu_gnt_v && (pick_idx == 2'(i))) begin
                    lu_buf_v[i] <= 1'b0;
                end else if (lu_valid[i] && !lu_buf_v[i]) begin
                    lu_buf_v[i]     <= 1'b1;
                    lu_buf[i].fp    <= lu_fp[i];
                    lu_buf[i].addr  <= lu_addr[5*i +: 5];
                    lu_buf[i].data  <= lu_data[DATA_W*i +: DATA_W];
                end
            end
            if (lu_gnt_v) begin
                rr_ptr <= 2'((32'(pick_idx) + 1) % NUM_LU);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write    <= 1'b0;
            reg_FP_write <= 1'b0;
            reg_rd_addr  <= '0;
            reg_rd_data  <= '0;
            grant_id     <= GNT_NONE;
        end else if (pipe_wb_valid) begin
            reg_write    <= !pipe_wb_fp && (pipe_wb_addr != '0);
            reg_FP_write <= pipe_wb_fp;
            reg_rd_addr  <= pipe_wb_addr;
            reg_rd_data  <= pipe_wb_data;
            grant_id     <= GNT_PIPE;
        end else if (lu_gnt_v) begin
            reg_write    <= !gnt_req.fp && (gnt_req.addr != '0);
            reg_FP_write <= gnt_req.fp;
            reg_rd_addr  <= gnt_req.addr;
            reg_rd_data  <= gnt_req.data;
            grant_id     <= {1'b0, pick_idx} + 3'd1;
        end else begin
            reg_write    <= 1'b0;
            reg_FP_write <= 1'b0;
            reg_rd_addr  <= '0;
            reg_rd_data  <= '0;
            grant_id     <= GNT_NONE;
        end
    end

    always_comb begin
        state_n      = state_q;
        starve_cnt_n = starve_cnt;
        proto_set    = 1'b0;
        case (state_q)
            ARB: begin
                if (lu_gnt_v || !(|lu_buf_v)) begin
                    starve_cnt_n = '0;
                end else if (starve_cnt == 8'(STARVE_MAX - 1)) begin
                    starve_cnt_n = '0;
                    state_n      = BUBBLE;
                end else begin
                    starve_cnt_n = starve_cnt + 8'd1;
                end
            end
            BUBBLE: begin
                starve_cnt_n = '0;
                if (pipe_wb_valid) begin
                    proto_set = 1'b1;
                    state_n   = BUBBLE;
                end else begin
                    state_n   = ARB;
                end
            end
            default: begin
                state_n      = ARB;
                starve_cnt_n = '0;
            end
        endcase
    end

    // pipe_stall is high exactly in the cycles the FSM sits in BUBBLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state_q    <= state_n;
            starve_cnt <= starve_cnt_n;
            pipe_stall <= (state_n == BUBBLE);
            if (proto_set) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef WB_ARB_HAZARD_EN
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        if (id_fp_read ? reg_FP_write : reg_write) begin
            if (reg_rd_addr == id_rs1_addr) hazard_rs1 = 1'b1;
            if (reg_rd_addr == id_rs2_addr) hazard_rs2 = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_LU; i++) begin
            if (lu_buf_v[i] && (lu_buf[i].fp == id_fp_read)) begin
                if (lu_buf[i].addr == id_rs1_addr) hazard_rs1 = 1'b1;
                if (lu_buf[i].addr == id_rs2_addr) hazard_rs2 = 1'b1;
            end
        end
        if (!id_fp_read) begin
            if (id_rs1_addr == '0) hazard_rs1 = 1'b0;
            if (id_rs2_addr == '0) hazard_rs2 = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (NUM_LU=2, STARVE_MAX=8, 32-bit data).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wb_valid;
    logic        pipe_wb_fp;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic [1:0]  lu_valid;
    logic [1:0]  lu_ready;
    logic [1:0]  lu_fp;
    logic [9:0]  lu_addr;
    logic [63:0] lu_data;
    logic        reg_write;
    logic        reg_FP_write;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [2:0]  grant_id;
    logic        pipe_stall;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .NUM_LU     (2),
        .STARVE_MAX (8),
        .DATA_W     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_fp    (pipe_wb_fp),
        .pipe_wb_addr  (pipe_wb_addr),
        .pipe_wb_data  (pipe_wb_data),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_fp         (lu_fp),
        .lu_addr       (lu_addr),
        .lu_data       (lu_data),
        .reg_write     (reg_write),
        .reg_FP_write  (reg_FP_write),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_data   (reg_rd_data),
        .grant_id      (grant_id),
        .pipe_stall    (pipe_stall),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic fp, input logic [4:0] a, input logic [31:0] d);
        pipe_wb_valid = v;
        pipe_wb_fp    = fp;
        pipe_wb_addr  = a;
        pipe_wb_data  = d;
    endtask

    task automatic lu_set(input int unsigned u, input logic fp, input logic [4:0] a, input logic [31:0] d);
        lu_fp[u]            = fp;
        lu_addr[5*u +: 5]   = a;
        lu_data[32*u +: 32] = d;
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic fw, input logic [4:0] a, input logic [2:0] g);
        check_eq({tag, ".reg_write"}, 64'(reg_write), 64'(w));
        check_eq({tag, ".reg_FP_write"}, 64'(reg_FP_write), 64'(fw));
        check_eq({tag, ".addr"}, 64'(reg_rd_addr), 64'(a));
        check_eq({tag, ".grant_id"}, 64'(grant_id), 64'(g));
    endtask

    initial begin
        rst = 1'b0;
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        lu_valid = '0;
        lu_fp    = '0;
        lu_addr  = '0;
        lu_data  = '0;
        step();
        step();
        chk_wr("reset", 1'b0, 1'b0, 5'd0, 3'd7);
        check_eq("reset.data", 64'(reg_rd_data), 64'd0);
        check_eq("reset.stall", 64'(pipe_stall), 64'd0);
        check_eq("reset.proto_err", 64'(proto_err), 64'd0);
        check_eq("reset.lu_ready", 64'(lu_ready), 64'd3);

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_wr("idle", 1'b0, 1'b0, 5'd0, 3'd7);
            check_eq("idle.lu_ready", 64'(lu_ready), 64'd3);
            check_eq("idle.stall", 64'(pipe_stall), 64'd0);
        end

        // Pipeline beats a simultaneous LU0 transfer; LU0 drains next cycle.
        pipe(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
        lu_set(0, 1'b0, 5'd6, 32'h0000_1234);
        lu_valid = 2'b01;
        step();
        chk_wr("pipe_first", 1'b1, 1'b0, 5'd5, 3'd0);
        check_eq("pipe_first.data", 64'(reg_rd_data), 64'hDEAD_BEEF);
        check_eq("pipe_first.lu_ready", 64'(lu_ready), 64'd2);
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        lu_valid = 2'b00;
        step();
        chk_wr("lu0_drain", 1'b1, 1'b0, 5'd6, 3'd1);
        check_eq("lu0_drain.data", 64'(reg_rd_data), 64'h0000_1234);
        check_eq("lu0_drain.lu_ready", 64'(lu_ready), 64'd3);

        // x0 suppression and f0 write
        pipe(1'b1, 1'b0, 5'd0, 32'h55);
        step();
        chk_wr("pipe_x0", 1'b0, 1'b0, 5'd0, 3'd0);
        pipe(1'b1, 1'b1, 5'd0, 32'h77);
        step();
        chk_wr("pipe_f0", 1'b0, 1'b1, 5'd0, 3'd0);
        check_eq("pipe_f0.data", 64'(reg_rd_data), 64'h77);
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk_wr("idle2", 1'b0, 1'b0, 5'd0, 3'd7);

        // LU1 integer x0 result: granted, no write (rr pointer sits at 1 here)
        lu_set(1, 1'b0, 5'd0, 32'h99);
        lu_valid = 2'b10;
        step();
        lu_valid = 2'b00;
        step();
        chk_wr("lu1_x0", 1'b0, 1'b0, 5'd0, 3'd2);

        // Round robin: pointer now 0
        lu_set(0, 1'b0, 5'd10, 32'hA0);
        lu_set(1, 1'b1, 5'd11, 32'hB0);
        lu_valid = 2'b11;
        step();
        check_eq("rr.load_ready", 64'(lu_ready), 64'd0);
        check_eq("rr.load_gid", 64'(grant_id), 64'd7);
        lu_valid = 2'b00;
        step();
        chk_wr("rr.g0", 1'b1, 1'b0, 5'd10, 3'd1);
        lu_set(0, 1'b0, 5'd12, 32'hA1);
        lu_valid = 2'b01;
        step();
        chk_wr("rr.g1", 1'b0, 1'b1, 5'd11, 3'd2);
        check_eq("rr.g1.data", 64'(reg_rd_data), 64'hB0);
        check_eq("rr.g1.lu_ready", 64'(lu_ready), 64'd2);
        lu_set(1, 1'b0, 5'd13, 32'hB1);
        lu_valid = 2'b10;
        pipe(1'b1, 1'b0, 5'd3, 32'h3);
        step();
        chk_wr("rr.block", 1'b1, 1'b0, 5'd3, 3'd0);
        check_eq("rr.block.lu_ready", 64'(lu_ready), 64'd0);
        lu_valid = 2'b00;
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk_wr("rr.wrap0", 1'b1, 1'b0, 5'd12, 3'd1);
        step();
        chk_wr("rr.wrap1", 1'b1, 1'b0, 5'd13, 3'd2);
        step();
        chk_wr("rr.idle", 1'b0, 1'b0, 5'd0, 3'd7);

        // Starvation: bubble request 8 cycles after buffering, then LU0 drains
        lu_set(0, 1'b0, 5'd20, 32'hC0);
        lu_valid = 2'b01;
        pipe(1'b1, 1'b0, 5'd7, 32'h1);
        step();
        lu_valid = 2'b00;
        check_eq("starve.c0", 64'(pipe_stall), 64'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check_eq("starve.wait", 64'(pipe_stall), 64'd0);
        end
        step();
        check_eq("starve.stall", 64'(pipe_stall), 64'd1);
        check_eq("starve.stall_gid", 64'(grant_id), 64'd0);
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk_wr("starve.drain", 1'b1, 1'b0, 5'd20, 3'd1);
        check_eq("starve.drain_stall", 64'(pipe_stall), 64'd0);
        check_eq("starve.drain_perr", 64'(proto_err), 64'd0);
        check_eq("starve.drain_ready", 64'(lu_ready), 64'd3);
        step();
        check_eq("starve.after", 64'(pipe_stall), 64'd0);

        // Protocol violation: pipe stays valid through the bubble
        lu_set(0, 1'b0, 5'd21, 32'hC1);
        lu_valid = 2'b01;
        pipe(1'b1, 1'b0, 5'd8, 32'h2);
        step();
        lu_valid = 2'b00;
        for (int i = 1; i < 8; i++) step();
        step();
        check_eq("perr.stall", 64'(pipe_stall), 64'd1);
        check_eq("perr.before", 64'(proto_err), 64'd0);
        step();
        check_eq("perr.set", 64'(proto_err), 64'd1);
        check_eq("perr.restall", 64'(pipe_stall), 64'd1);
        check_eq("perr.pipe_gid", 64'(grant_id), 64'd0);
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk_wr("perr.drain", 1'b1, 1'b0, 5'd21, 3'd1);
        check_eq("perr.drain_stall", 64'(pipe_stall), 64'd0);
        step();
        step();
        check_eq("perr.sticky", 64'(proto_err), 64'd1);

        // Reset while both buffers hold results
        lu_set(0, 1'b0, 5'd22, 32'hD0);
        lu_set(1, 1'b0, 5'd23, 32'hD1);
        lu_valid = 2'b11;
        pipe(1'b1, 1'b0, 5'd9, 32'h3);
        step();
        check_eq("rstmid.held", 64'(lu_ready), 64'd0);
        lu_valid = 2'b00;
        pipe(1'b0, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        step();
        check_eq("rstmid.ready", 64'(lu_ready), 64'd3);
        check_eq("rstmid.perr", 64'(proto_err), 64'd0);
        chk_wr("rstmid.out", 1'b0, 1'b0, 5'd0, 3'd7);
        rst = 1'b1;
        step();
        chk_wr("rstmid.nodrain", 1'b0, 1'b0, 5'd0, 3'd7);
        check_eq("rstmid.ready2", 64'(lu_ready), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
